// File: rtl/step_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and 4-state FSM
// producing a one-clock step pulse plus a debounced level. Define STEP_AUTOREPEAT_EN for hold-to-repeat.
module step_debouncer #(
  parameter int unsigned STABLE_COUNT  = 1000000,
  parameter int unsigned CNT_WIDTH     = 20,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned RPT_WIDTH     = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic step_pulse,
  output logic btn_level
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 32'd1);

  // Reject configurations where the counters could wrap or the terminal compare is meaningless
  if ((STABLE_COUNT < 32'd2) || ((64'd1 << CNT_WIDTH) <= 64'(STABLE_COUNT))) begin : g_bad_cnt_cfg
    $fatal(1, "step_debouncer: STABLE_COUNT must be >= 2 and fit in CNT_WIDTH");
  end
  if ((REPEAT_PERIOD < 32'd1) || (REPEAT_PERIOD > REPEAT_DELAY) ||
      ((64'd1 << RPT_WIDTH) <= 64'(REPEAT_DELAY))) begin : g_bad_rpt_cfg
    $fatal(1, "step_debouncer: repeat timing must satisfy 1 <= PERIOD <= DELAY < 2^RPT_WIDTH");
  end

  logic                 sync1_q, sync2_q;
  logic                 btn_sync;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 step_pulse_q, step_pulse_d;
  logic                 btn_level_q, btn_level_d;

`ifdef STEP_AUTOREPEAT_EN
  localparam logic [RPT_WIDTH-1:0] RPT_LAST   = RPT_WIDTH'(REPEAT_DELAY - 32'd1);
  localparam logic [RPT_WIDTH-1:0] RPT_RELOAD = RPT_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RPT_WIDTH-1:0] rpt_q, rpt_d;
`endif

  assign btn_sync   = sync2_q;
  assign step_pulse = step_pulse_q;
  assign btn_level  = btn_level_q;

  // Next-state logic: every state exit clears the counter so it can never wrap
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    step_pulse_d = 1'b0;
    btn_level_d  = btn_level_q;
`ifdef STEP_AUTOREPEAT_EN
    rpt_d        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = PRESSED;
          step_pulse_d = 1'b1;
          btn_level_d  = 1'b1;
          cnt_d        = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
`ifdef STEP_AUTOREPEAT_EN
          // Reload keeps every later repeat exactly REPEAT_PERIOD cycles apart
          if (rpt_q == RPT_LAST) begin
            step_pulse_d = 1'b1;
            rpt_d        = RPT_RELOAD;
          end else begin
            rpt_d = rpt_q + RPT_WIDTH'(1);
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          btn_level_d = 1'b0;
          cnt_d       = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = CNT_ZERO;
        btn_level_d = 1'b0;
      end
    endcase
  end

  // State, synchronizer and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      step_pulse_q <= 1'b0;
      btn_level_q  <= 1'b0;
`ifdef STEP_AUTOREPEAT_EN
      rpt_q        <= '0;
`endif
    end else begin
      sync1_q      <= btn_in;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_pulse_q <= step_pulse_d;
      btn_level_q  <= btn_level_d;
`ifdef STEP_AUTOREPEAT_EN
      rpt_q        <= rpt_d;
`endif
    end
  end

endmodule

// File: tb/tb_step_debouncer.sv
// Directed bench for step_debouncer with STABLE_COUNT=4; repeat checks run when STEP_AUTOREPEAT_EN is defined.
module tb_step_debouncer;
  localparam int unsigned SC = 4;

  logic clock = 1'b0;
  logic reset;
  logic btn_in;
  logic step_pulse;
  logic btn_level;

  int total  = 0;
  int bad    = 0;
  int tick_n = 0;

  typedef struct {
    logic rst;
    logic btn;
    logic exp_pulse;
    logic exp_level;
  } vec_t;

  vec_t vq[$];

  step_debouncer #(
    .STABLE_COUNT (SC),
    .CNT_WIDTH    (3),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(5),
    .RPT_WIDTH    (5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_in    (btn_in),
    .step_pulse(step_pulse),
    .btn_level (btn_level)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s tick=%0d got=%b want=%b", name, tick_n, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the next falling edge
  task automatic tick(input logic r, input logic b);
    reset  = r;
    btn_in = b;
    @(posedge clock);
    @(negedge clock);
    tick_n++;
  endtask

  // n ticks at level b; pulse expected only at tick pulse_at (0 = never),
  // level switches from lvl_before to lvl_after at tick lvl_from (0 = never)
  task automatic hold(input logic b, input int n, input int pulse_at, input int lvl_from,
                      input logic lvl_before, input logic lvl_after, input string name);
    for (int i = 1; i <= n; i++) begin
      tick(1'b0, b);
      check({name, "_pulse"}, step_pulse, (i == pulse_at) ? 1'b1 : 1'b0);
      check({name, "_level"}, btn_level, (lvl_from != 0 && i >= lvl_from) ? lvl_after : lvl_before);
    end
  endtask

  task automatic add(input logic r, input logic b, input logic p, input logic l);
    vec_t v;
    v.rst = r; v.btn = b; v.exp_pulse = p; v.exp_level = l;
    vq.push_back(v);
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;

    // Reset held with button down, clean press after release, then clean release
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].rst, vq[i].btn);
      check("vec_pulse", step_pulse, vq[i].exp_pulse);
      check("vec_level", btn_level, vq[i].exp_level);
    end

`ifndef STEP_AUTOREPEAT_EN
    // Long hold: one pulse only
    hold(1'b1, 106, SC + 2, SC + 2, 1'b0, 1'b1, "long_hold");
    hold(1'b0, 8, 0, SC + 2, 1'b1, 1'b0, "long_rel");
`endif

    // Press bounce 1,1,0,0,1,1,0,0 then steady high
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, (i % 4 < 2) ? 1'b1 : 1'b0);
      check("pbounce_pulse", step_pulse, 1'b0);
      check("pbounce_level", btn_level, 1'b0);
    end
    hold(1'b1, 12, SC + 2, SC + 2, 1'b0, 1'b1, "pbounce_hold");
    hold(1'b0, 8, 0, SC + 2, 1'b1, 1'b0, "pbounce_rel");

    // Release bounce 0,0,1,1 then steady low
    hold(1'b1, 8, SC + 2, SC + 2, 1'b0, 1'b1, "rbounce_press");
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, (i < 2) ? 1'b0 : 1'b1);
      check("rbounce_pulse", step_pulse, 1'b0);
      check("rbounce_level", btn_level, 1'b1);
    end
    hold(1'b0, 8, 0, SC + 2, 1'b1, 1'b0, "rbounce_rel");

    // Reset while counting in PRESS_WAIT (cnt=2), button still held afterwards
    hold(1'b1, 4, 0, 0, 1'b0, 1'b0, "mid_pre");
    tick(1'b1, 1'b1);
    check("mid_rst_pulse", step_pulse, 1'b0);
    check("mid_rst_level", btn_level, 1'b0);
    hold(1'b1, 8, SC + 2, SC + 2, 1'b0, 1'b1, "mid_post");
    hold(1'b0, 8, 0, SC + 2, 1'b1, 1'b0, "mid_rel");

    // Reset on the very edge that would have produced the pulse
    hold(1'b1, 5, 0, 0, 1'b0, 1'b0, "edge_pre");
    tick(1'b1, 1'b1);
    check("edge_rst_pulse", step_pulse, 1'b0);
    check("edge_rst_level", btn_level, 1'b0);
    hold(1'b1, 8, SC + 2, SC + 2, 1'b0, 1'b1, "edge_post");
    hold(1'b0, 8, 0, SC + 2, 1'b1, 1'b0, "edge_rel");

`ifdef STEP_AUTOREPEAT_EN
    // Hold-to-repeat: first pulse at tick 6, repeats at 26 and every 5 after
    for (int i = 1; i <= 62; i++) begin
      tick(1'b0, 1'b1);
      check("rpt_pulse", step_pulse, ((i == 6) || (i >= 26 && (i - 26) % 5 == 0)) ? 1'b1 : 1'b0);
      check("rpt_level", btn_level, (i >= 6) ? 1'b1 : 1'b0);
    end
    hold(1'b0, 8, 0, SC + 2, 1'b1, 1'b0, "rpt_rel");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
